load_store_unit: RTL and testbench

- Initiator side of the data-memory interface: accepts one load/store request at a time from the execute stage and drives a word-addressed, byte-enabled memory port with a req/gnt/rvalid protocol.
- Generates byte enables and aligned write data.
- Extracts, merges and sign/zero-extends read data.
- Optionally splits misaligned accesses into two word accesses.
- Sits between the RV32I execute stage and the data memory.

---
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory initiator with byte enables, lane alignment and load extension.
// Define MISALIGN_SPLIT_EN to split misaligned half/word accesses into two word beats.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sign_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
`ifdef MISALIGN_SPLIT_EN
  localparam int MW = 8;
`else
  localparam int MW = 4;
`endif
  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} state_t;
  state_t state_q, state_d;
  logic [29:0] aw_q, aw_d;
  logic [1:0] off_q, off_d, size_q, size_d;
  logic [MW-1:0] mask_q, mask_d;
  logic we_q, we_d, sign_q, sign_d, err_q, err_d;
  logic [31:0] wd_q, wd_d, data_q, data_d, ext_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] mask_c;
  logic [5:0] sh_c, sh_q;
  logic [3:0] be2_d;
  logic tmo, err_c, split_q, beat_d;
  logic req_ready_q, rsp_valid_q, rsp_err_q, mem_req_q, mem_we_q;
  logic [31:0] rsp_rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0] mem_be_q;
  assign sh_c = {1'b0, req_addr_i[1:0], 3'b000};
  assign sh_q = {1'b0, off_q, 3'b000};
  assign mask_c = {4'h0, req_size_i == 2'b00 ? 4'h1 : req_size_i == 2'b01 ? 4'h3 : 4'hF} << req_addr_i[1:0];
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt_q == TMAX);
`ifdef MISALIGN_SPLIT_EN
  assign err_c = &req_size_i;
  assign split_q = |mask_q[7:4];
  assign be2_d = mask_d[7:4];
`else
  // Without splitting, any access whose mask spills past the word is rejected.
  assign err_c = (&req_size_i) | (|mask_c[7:4]);
  assign split_q = 1'b0;
  assign be2_d = 4'h0;
`endif
  always_comb begin
    state_d = state_q;
    aw_d = aw_q;
    off_d = off_q;
    size_d = size_q;
    mask_d = mask_q;
    we_d = we_q;
    sign_d = sign_q;
    wd_d = wd_q;
    data_d = data_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        aw_d = req_addr_i[31:2];
        off_d = req_addr_i[1:0];
        size_d = req_size_i;
        mask_d = mask_c[MW-1:0];
        we_d = req_we_i;
        sign_d = req_sign_i;
        wd_d = (req_wdata_i << sh_c) | (req_wdata_i >> (6'd32 - sh_c));
        data_d = '0;
        err_d = err_c;
        state_d = err_c ? RESP : REQ1;
      end
      REQ1: begin
        state_d = tmo ? RESP : mem_gnt_i ? WAIT1 : REQ1;
        err_d = tmo;
      end
      WAIT1: begin
        state_d = tmo ? RESP : !mem_rvalid_i ? WAIT1 : split_q ? REQ2 : RESP;
        data_d = mem_rvalid_i ? mem_rdata_i >> sh_q : data_q;
        err_d = tmo;
      end
`ifdef MISALIGN_SPLIT_EN
      REQ2: begin
        state_d = tmo ? RESP : mem_gnt_i ? WAIT2 : REQ2;
        err_d = tmo;
      end
      WAIT2: begin
        state_d = tmo ? RESP : mem_rvalid_i ? RESP : WAIT2;
        data_d = mem_rvalid_i ? data_q | (mem_rdata_i << (6'd32 - sh_q)) : data_q;
        err_d = tmo;
      end
`endif
      default: state_d = IDLE;
    endcase
    cnt_d = (state_q == IDLE || state_q == RESP || (state_q == WAIT1 && state_d == REQ2)) ? '0 : cnt_q + CW'(1);
    ext_d = size_d == 2'b00 ? {{24{sign_d & data_d[7]}}, data_d[7:0]} :
            size_d == 2'b01 ? {{16{sign_d & data_d[15]}}, data_d[15:0]} : data_d;
    beat_d = state_d == REQ1 || state_d == REQ2;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aw_q <= '0;
      off_q <= '0;
      size_q <= '0;
      mask_q <= '0;
      we_q <= 1'b0;
      sign_q <= 1'b0;
      wd_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_be_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      aw_q <= aw_d;
      off_q <= off_d;
      size_q <= size_d;
      mask_q <= mask_d;
      we_q <= we_d;
      sign_q <= sign_d;
      wd_q <= wd_d;
      data_q <= data_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      req_ready_q <= state_d == IDLE;
      rsp_valid_q <= state_d == RESP;
      rsp_err_q <= state_d == RESP && err_d;
      rsp_rdata_q <= (state_d == RESP && !err_d && !we_d) ? ext_d : '0;
      mem_req_q <= beat_d;
      mem_we_q <= beat_d && we_d;
      mem_be_q <= state_d == REQ1 ? mask_d[3:0] : state_d == REQ2 ? be2_d : 4'h0;
      mem_addr_q <= {aw_d + 30'(state_d == REQ2), 2'b00};
      mem_wdata_q <= wd_d;
    end
  end
  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o = rsp_err_q;
  assign mem_req_o = mem_req_q;
  assign mem_we_o = mem_we_q;
  assign mem_be_o = mem_be_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus timeout and mid-transfer reset sequences.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid, req_ready, req_we, req_sign, rsp_valid, rsp_err;
  logic mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  int checks = 0;
  int failures = 0;
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_sign_i(req_sign), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );
  typedef struct {
    logic we; logic [1:0] size; logic sign; logic [31:0] addr; logic [31:0] wdata;
    logic err; logic [31:0] rdata; int lat; int nb;
    logic [31:0] a0; logic [3:0] be0; logic [31:0] wd0; logic [31:0] a1; logic [3:0] be1;
  } vec_t;
  vec_t v [10];
  logic [31:0] ba [2];
  logic [3:0] bb [2];
  logic [31:0] bw [2];
  logic bwe [2];
  int nb, lat;
  logic got, r_err, seen;
  logic [31:0] r_dat;
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h80FF1234;
      32'h0000_0300: return 32'h44332211;
      32'h0000_0304: return 32'h88776655;
      32'h0000_0000: return 32'h000000CC;
      default:       return 32'hDEADBEEF;
    endcase
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_sign = sg; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic run(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
    logic pend;
    logic [31:0] pa;
    pend = 1'b0; pa = '0; nb = 0; lat = 0; got = 1'b0; r_err = 1'b0; r_dat = '0;
    issue(we, sz, sg, a, wd);
    for (int c = 1; c < 40 && !got; c++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (rsp_valid) begin
        got = 1'b1; lat = c; r_err = rsp_err; r_dat = rsp_rdata;
      end else if (pend) begin
        mem_rvalid = 1'b1; mem_rdata = mem_rd(pa); pend = 1'b0;
      end else if (mem_req) begin
        if (nb < 2) begin
          ba[nb] = mem_addr; bb[nb] = mem_be; bw[nb] = mem_wdata; bwe[nb] = mem_we;
        end
        nb++; mem_gnt = 1'b1; pend = 1'b1; pa = mem_addr;
      end
      if (!got) @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask
  initial begin
    req_valid = 0; req_we = 0; req_size = 0; req_sign = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    v[0] = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b0, 32'hFFFFFF80, 3, 1, 32'h100, 4'b1000, 32'h0, 32'h0, 4'h0};
    v[1] = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b0, 32'h00000080, 3, 1, 32'h100, 4'b1000, 32'h0, 32'h0, 4'h0};
    v[2] = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF, 1'b0, 32'h0, 3, 1, 32'h200, 4'b1100, 32'hBEEF0000, 32'h0, 4'h0};
    v[3] = '{1'b0, 2'd2, 1'b1, 32'h100, 32'h0, 1'b0, 32'h80FF1234, 3, 1, 32'h100, 4'b1111, 32'h0, 32'h0, 4'h0};
    v[4] = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1'b0, 32'hFFFF80FF, 3, 1, 32'h100, 4'b1100, 32'h0, 32'h0, 4'h0};
    v[5] = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    v[6] = '{1'b1, 2'd0, 1'b0, 32'h101, 32'h123456AB, 1'b0, 32'h0, 3, 1, 32'h100, 4'b0010, 32'h3456AB12, 32'h0, 4'h0};
    v[7] = '{1'b0, 2'd1, 1'b0, 32'h301, 32'h0, 1'b0, 32'h00003322, 3, 1, 32'h300, 4'b0110, 32'h0, 32'h0, 4'h0};
`ifdef MISALIGN_SPLIT_EN
    v[8] = '{1'b0, 2'd2, 1'b0, 32'h301, 32'h0, 1'b0, 32'h55443322, 5, 2, 32'h300, 4'b1110, 32'h0, 32'h304, 4'b0001};
    v[9] = '{1'b0, 2'd1, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0, 32'hFFFFCCDE, 5, 2, 32'hFFFFFFFC, 4'b1000, 32'h0, 32'h0, 4'b0001};
`else
    v[8] = '{1'b0, 2'd2, 1'b0, 32'h301, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    v[9] = '{1'b0, 2'd1, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst req_ready", req_ready, 1);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst rsp_err", rsp_err, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_be", mem_be, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    for (int i = 0; i < 10; i++) begin
      run(v[i].we, v[i].size, v[i].sign, v[i].addr, v[i].wdata);
      chk($sformatf("v%0d got", i), got, 1);
      chk($sformatf("v%0d err", i), r_err, v[i].err);
      chk($sformatf("v%0d rdata", i), r_dat, v[i].rdata);
      chk($sformatf("v%0d latency", i), lat, v[i].lat);
      chk($sformatf("v%0d beats", i), nb, v[i].nb);
      if (v[i].nb >= 1 && nb >= 1) begin
        chk($sformatf("v%0d addr0", i), ba[0], v[i].a0);
        chk($sformatf("v%0d be0", i), bb[0], v[i].be0);
        chk($sformatf("v%0d we0", i), bwe[0], v[i].we);
        chk($sformatf("v%0d wdata0", i), bw[0], v[i].wd0);
      end
      if (v[i].nb == 2 && nb == 2) begin
        chk($sformatf("v%0d addr1", i), ba[1], v[i].a1);
        chk($sformatf("v%0d be1", i), bb[1], v[i].be1);
      end
    end
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("stall%0d mem_req", c), mem_req, 1);
      chk($sformatf("stall%0d mem_addr", c), mem_addr, 32'h100);
      chk($sformatf("stall%0d mem_be", c), mem_be, 4'hF);
      chk($sformatf("stall%0d req_ready", c), req_ready, 0);
      @(negedge clk);
    end
    chk("timeout rsp_valid", rsp_valid, 1);
    chk("timeout rsp_err", rsp_err, 1);
    chk("timeout rsp_rdata", rsp_rdata, 0);
    chk("timeout mem_req", mem_req, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    chk("rstmid mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstmid wait mem_req", mem_req, 0);
    chk("rstmid wait req_ready", req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rstmid async mem_req", mem_req, 0);
    chk("rstmid async rsp_valid", rsp_valid, 0);
    chk("rstmid async req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid release req_ready", req_ready, 1);
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF1234;
    @(negedge clk);
    mem_rvalid = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("rstmid late rvalid rsp", seen, 0);
    chk("rstmid idle req_ready", req_ready, 1);
    run(v[3].we, v[3].size, v[3].sign, v[3].addr, v[3].wdata);
    chk("recover rdata", r_dat, v[3].rdata);
    chk("recover latency", lat, v[3].lat);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
